// File: rtl/out_bcd_latch_pkg.sv
// Shared types and constants for the OUT-port BCD latch and its double-dabble step.
package out_bcd_latch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = 4 * BCD_DIGITS;
    localparam int ADD3_THRESH = 5;

endpackage

// File: rtl/out_bcd_latch_bcd_add3_shift.sv
// One combinational double-dabble iteration: add 3 to every BCD nibble >= 5,
// then shift {bcd, mag} left by one bit.
module bcd_add3_shift
    import out_bcd_latch_pkg::*;
#(
    parameter int MAG_W = 10
) (
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [MAG_W-1:0] mag_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic [MAG_W-1:0] mag_out
);

    logic [BCD_W-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_in;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_in[4*d +: 4] >= 4'(ADD3_THRESH))
                bcd_adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
        end
    end

    assign bcd_out = {bcd_adj[BCD_W-2:0], mag_in[MAG_W-1]};
    assign mag_out = {mag_in[MAG_W-2:0], 1'b0};

endmodule

// File: rtl/out_bcd_latch.sv
// OUT-port latch: captures the operand, converts its low BITS2 bits (two's complement)
// to sign + 3 BCD digits, and commits all display outputs atomically.
//   state     | meaning
//   ST_IDLE   | waiting for an OUT strobe
//   ST_CONV   | one double-dabble iteration per clock (BITS2 iterations)
//   ST_COMMIT | publish result, then start pending/simultaneous strobe or go idle
module out_bcd_latch
    import out_bcd_latch_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int BITS2 = 10,
    parameter int CNT_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            out_strobe,
    input  logic            clear,
    input  logic [BITS-1:0] value_in,
    output logic [BITS-1:0] value_q,
    output logic            flag_out,
    output logic            sign,
    output logic [3:0]      hundred,
    output logic [3:0]      ten,
    output logic [3:0]      one,
    output logic            busy,
    output logic            done
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [BITS-1:0]   cap_value, pend_value, load_value;
    logic              cap_sign, pend_valid;
    logic [BCD_W-1:0]  bcd_acc, bcd_next, bcd_q;
    logic [BITS2-1:0]  mag_acc, mag_next, load_field, load_mag;
    logic              load_en, commit_en, pend_set, pend_clr, last_iter;

    assign last_iter  = (cnt == CNT_W'(BITS2 - 1));
    assign load_field = load_value[BITS2-1:0];
    // -512 negates to itself, which read unsigned is the correct magnitude 512.
    assign load_mag   = load_field[BITS2-1] ? ((~load_field) + BITS2'(1)) : load_field;

    bcd_add3_shift #(.MAG_W(BITS2)) u_step (
        .bcd_in  (bcd_acc),
        .mag_in  (mag_acc),
        .bcd_out (bcd_next),
        .mag_out (mag_next)
    );

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        load_value = value_in;
        commit_en  = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (out_strobe) begin
                    load_en    = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                pend_set = out_strobe;
                if (last_iter)
                    state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit_en = 1'b1;
                pend_clr  = 1'b1;
                if (out_strobe || pend_valid) begin
                    load_en    = 1'b1;
                    load_value = out_strobe ? value_in : pend_value;
                    state_next = ST_CONV;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            cap_value  <= '0;
            cap_sign   <= 1'b0;
            mag_acc    <= '0;
            bcd_acc    <= '0;
            pend_valid <= 1'b0;
            pend_value <= '0;
            value_q    <= '0;
            sign       <= 1'b0;
            bcd_q      <= '0;
            flag_out   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= commit_en;
            if (load_en) begin
                cap_value <= load_value;
                cap_sign  <= load_field[BITS2-1];
                mag_acc   <= load_mag;
                bcd_acc   <= '0;
                cnt       <= '0;
            end else if (state == ST_CONV) begin
                mag_acc <= mag_next;
                bcd_acc <= bcd_next;
                cnt     <= cnt + CNT_W'(1);
            end
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_value <= value_in;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
            // A commit on the same edge as clear keeps the display enabled.
            if (commit_en) begin
                value_q  <= cap_value;
                sign     <= cap_sign;
                bcd_q    <= bcd_acc;
                flag_out <= 1'b1;
            end else if (clear) begin
                flag_out <= 1'b0;
            end
        end
    end

    assign busy    = (state != ST_IDLE);
    assign hundred = bcd_q[11:8];
    assign ten     = bcd_q[7:4];
    assign one     = bcd_q[3:0];

endmodule

// File: tb/tb_out_bcd_latch.sv
// Self-checking bench for out_bcd_latch: directed scenarios plus randomized operands
// checked against an arithmetic (divide/modulo) model of the displayed value.
module tb_out_bcd_latch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        out_strobe = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] value_in = '0;
    logic [31:0] value_q;
    logic        flag_out, sign, busy, done;
    logic [3:0]  hundred, ten, one;
    logic [12:0] disp;

    int checks = 0;
    int failures = 0;

    out_bcd_latch #(.BITS(32), .BITS2(10), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .out_strobe (out_strobe),
        .clear      (clear),
        .value_in   (value_in),
        .value_q    (value_q),
        .flag_out   (flag_out),
        .sign       (sign),
        .hundred    (hundred),
        .ten        (ten),
        .one        (one),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;
    assign disp = {sign, hundred, ten, one};

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] model_disp(input logic [31:0] v);
        int f, m;
        logic s;
        f = int'(v & 32'h3FF);
        s = (f >= 512);
        m = s ? 1024 - f : f;
        return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic strobe(input logic [31:0] v);
        @(negedge clock);
        value_in   = v;
        out_strobe = 1'b1;
        @(negedge clock);
        out_strobe = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({value_q, flag_out, disp, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_state got value_q=%h flag=%b disp=%h busy=%b done=%b exp all zero",
                     value_q, flag_out, disp, busy, done);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int bad = 0;
        strobe(32'd123);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_e0 got=%b exp=1", busy);
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_busy_window got=%0d bad cycles exp=0", bad);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_e11 got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        checks++;
        if (disp !== 13'h0123 || flag_out !== 1'b1 || value_q !== 32'd123) begin
            failures++;
            $display("FAIL basic_result got disp=%h flag=%b value_q=%h exp disp=0123 flag=1 value_q=0000007b",
                     disp, flag_out, value_q);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_signed();
        logic [31:0] vals [3] = '{32'h0000_03FB, 32'h0000_0200, 32'd511};
        logic [12:0] exps [3] = '{13'h1005, 13'h1512, 13'h0511};
        int lat;
        for (int k = 0; k < 3; k++) begin
            strobe(vals[k]);
            wait_done(lat);
            checks++;
            if (lat != 11 || disp !== exps[k] || value_q !== vals[k]) begin
                failures++;
                $display("FAIL signed_%0d got lat=%0d disp=%h value_q=%h exp lat=11 disp=%h value_q=%h",
                         k, lat, disp, value_q, exps[k], vals[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        logic [12:0] d0 = '0, d1 = '0;
        strobe(32'd7);
        @(negedge clock);
        @(negedge clock);
        value_in = 32'd42; out_strobe = 1'b1;
        @(negedge clock);
        out_strobe = 1'b0;
        @(negedge clock);
        value_in = 32'd99; out_strobe = 1'b1;
        @(negedge clock);
        out_strobe = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (nd == 0) d0 = disp;
                else if (nd == 1) d1 = disp;
                nd++;
            end
        end
        checks++;
        if (nd != 2) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=2", nd);
        end
        checks++;
        if (d0 !== 13'h0007 || d1 !== 13'h0099) begin
            failures++;
            $display("FAIL b2b_values got first=%h second=%h exp first=0007 second=0099", d0, d1);
        end
    endtask

    task automatic test_clear();
        int lat;
        strobe(32'd250);
        wait_done(lat);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (flag_out !== 1'b0 || disp !== 13'h0250 || value_q !== 32'd250) begin
            failures++;
            $display("FAIL clear_hold got flag=%b disp=%h value_q=%h exp flag=0 disp=0250 value_q=000000fa",
                     flag_out, disp, value_q);
        end
        // clear sampled on the commit edge: commit must win.
        strobe(32'd0);
        repeat (10) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (done !== 1'b1 || flag_out !== 1'b1 || disp !== 13'h0000) begin
            failures++;
            $display("FAIL clear_vs_commit got done=%b flag=%b disp=%h exp done=1 flag=1 disp=0000",
                     done, flag_out, disp);
        end
    endtask

    task automatic test_upper_bits();
        int lat;
        strobe(32'hFFFF_F064);
        wait_done(lat);
        checks++;
        if (disp !== 13'h0100 || value_q !== 32'hFFFF_F064) begin
            failures++;
            $display("FAIL upper_bits got disp=%h value_q=%h exp disp=0100 value_q=fffff064", disp, value_q);
        end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        int lat;
        strobe(32'd300);
        repeat (5) @(negedge clock);
        #7;
        reset = 1'b1;
        #1;
        checks++;
        if ({value_q, flag_out, disp, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid got value_q=%h flag=%b disp=%h busy=%b done=%b exp all zero",
                     value_q, flag_out, disp, busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d exp=0", nd);
        end
        strobe(32'd8);
        wait_done(lat);
        checks++;
        if (lat != 11 || disp !== 13'h0008 || flag_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after got lat=%0d disp=%h flag=%b exp lat=11 disp=0008 flag=1",
                     lat, disp, flag_out);
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [5] = '{32'h200, 32'h1FF, 32'h3FF, 32'h0, 32'h201};
        logic [31:0] v;
        logic [12:0] exp_d;
        int lat;
        for (int k = 0; k < 30; k++) begin
            v = $urandom;
            if ($urandom_range(0, 3) == 0)
                v = (v & 32'hFFFF_FC00) | edges[$urandom_range(0, 4)];
            exp_d = model_disp(v);
            strobe(v);
            wait_done(lat);
            checks++;
            if (lat != 11 || disp !== exp_d || value_q !== v || flag_out !== 1'b1) begin
                failures++;
                $display("FAIL random_%0d v=%h got lat=%0d disp=%h value_q=%h flag=%b exp lat=11 disp=%h",
                         k, v, lat, disp, value_q, flag_out, exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_clear();
        test_upper_bits();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_bcd_latch.md
Name: out_bcd_latch

Overview:
- Output-port stage sitting directly upstream of the 7-segment display stage.
- Captures the processor's OUT-instruction operand on a one-cycle strobe.
- Converts the low BITS2 bits, read as two's complement, to sign plus three BCD digits with a multi-cycle shift-add-3 (double-dabble) engine.
- Presents held value, sign, digits and the display-enable flag, updated atomically only when a conversion completes, so the display never shows partial results.

Parameters:
- BITS, 32, width of the processor data word
- BITS2, 10, number of low bits displayed, interpreted as two's complement
- CNT_W, 4, width of the iteration counter; must satisfy 2^CNT_W > BITS2

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- out_strobe  input  1  one-cycle pulse from the OUT instruction; capture value_in
- clear  input  1  blank the display (drop flag_out); does not abort a conversion
- value_in  input  BITS  operand to display
- value_q  output  BITS  full value of the last committed operand
- flag_out  output  1  display enable for the downstream stage
- sign  output  1  1 when the committed BITS2 field is negative
- hundred  output  4  BCD hundreds digit of the magnitude
- ten  output  4  BCD tens digit
- one  output  4  BCD ones digit
- busy  output  1  conversion in progress (states CONV or COMMIT)
- done  output  1  one-cycle pulse when a new result is committed

Behaviour:
- Reset (async, reset=1): state IDLE; value_q=0, flag_out=0, sign=0, hundred=ten=one=0, busy=0, done=0; pending buffer empty; iteration counter=0.
- Magnitude: field f = value_in[BITS2-1:0]. If f[BITS2-1]=1, mag = -f (BITS2-bit two's-complement negate), else mag = f. -512 gives mag=512 (10'h200 unsigned). Maximum magnitude is 512, so 3 digits always suffice.
- States:
  - IDLE: strobe → latch value_in, sign, mag; clear the 12-bit BCD accumulator; cnt=0; go CONV.
  - CONV: each edge performs one double-dabble iteration: add 3 to every BCD nibble ≥5, then shift {bcd,mag} left 1. At cnt=BITS2-1 go COMMIT, else cnt+1.
  - COMMIT: copy the captured value, sign and BCD nibbles to the outputs; set flag_out=1; pulse done. If pending is valid, load it exactly as IDLE would and go CONV (pending cleared); else go IDLE.
- Latency: strobe sampled at edge E0, iterations at E1..E10, commit at E11. Outputs and done are visible after E11. busy is high from after E0 through the cycle following E10.
- Strobe while busy: value goes into a one-deep pending buffer; newest wins, overwriting any older pending value. The in-flight conversion is not disturbed.
- Strobe in the same cycle as COMMIT: it is the pending source. If pending was already valid, the strobe value replaces it.
- clear: at the next edge flag_out=0. Digits, sign and value_q are held. A later COMMIT sets flag_out=1 again. clear and COMMIT on the same edge: COMMIT wins (flag_out=1).
- done is high for exactly one cycle per commit; done=0 in every other state.
- Reset mid-conversion: everything returns to reset values immediately; the in-flight result and pending value are discarded.
- value_in bits above BITS2 do not affect sign or digits; they are carried in value_q only.

Decomposition:
- Shared package: state encoding (IDLE, CONV, COMMIT), BCD_DIGITS=3, and the constant ADD3_THRESH=5.
- One natural sub-module, bcd_add3_shift: combinational single iteration of double dabble, taking {bcd[11:0], mag[BITS2-1:0]} to the next value. The FSM instantiates it once and iterates.

Test Plan:
- Reset, then strobe value_in=123 → busy for 11 cycles; after E11 done=1 for one cycle, flag_out=1, sign=0, digits 1/2/3, value_q=123.
- Strobe value_in=32'h000003FB (-5 in 10 bits) → sign=1, digits 0/0/5. Then strobe 32'h00000200 → sign=1, digits 5/1/2. Then strobe 511 → sign=0, digits 5/1/1.
- Strobe 7; at E3 strobe 42; at E5 strobe 99 → first commit shows 7; second conversion shows 99 (42 dropped). Exactly two done pulses.
- Commit 250, then assert clear for 1 cycle → flag_out=0, digits still 2/5/0. Next strobe 0 → flag_out=1, digits 0/0/0, sign=0.
- Strobe 300, assert reset asynchronously at E6 mid-cycle → all outputs 0 immediately, no done pulse. After reset release, strobe 8 → digits 0/0/8 with latency 11.
- Strobe 32'hFFFF_F064 (field 10'h064=100) → sign=0, digits 1/0/0, value_q=32'hFFFF_F064.
